mcdf_arbiter: RTL

Priority arbiter for the three-slave MCDF datapath; the driving end of the arbiter bus that the arbiter monitor samples (slave priorities/requests in, per-slave acks out, formatter id request in). On each formatter id request it selects one requesting slave by priority, acknowledges it with a one-cycle pulse, presents the packet id/length to the formatter, then forwards exactly that packet's data words before re-arbitrating.

---
 rtl/mcdf_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter
// Priority arbiter for the three-slave MCDF datapath. On a formatter id
// request it picks one requesting slave by priority, acknowledges it with a
// one-cycle pulse, presents the packet id/length to the formatter and then
// forwards exactly len+1 data words from that slave before re-arbitrating.
//
// Ports:
//   clk, rstn                 clock (rising edge), async active-low reset
//   slv_prios[5:0]            2-bit priority per slave, 0 highest
//   slv_reqs[2:0]             slave holds a complete packet
//   slv_vals[2:0]             slave data word valid
//   slv_datas[3*DW-1:0]       slave data, slave i at [DW*i +: DW]
//   slv_ids[23:0]             8-bit packet id per slave
//   slv_lens[23:0]            8-bit length per slave (len+1 words)
//   f2a_id_req                formatter ready for a new packet header
//   a2s_acks[2:0]             one-hot one-cycle grant
//   a2f_val, a2f_data         forwarded data word and its valid
//   a2f_id, a2f_len           header of the granted packet
//   a2f_busy                  high from grant until the last word
//
// Build option: define MCDF_ARB_RR_EN to break equal-priority ties
// round-robin starting after the last winner; otherwise the lowest slave
// index wins ties.

module mcdf_arbiter #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [5:0]      slv_prios,
    input  logic [2:0]      slv_reqs,
    input  logic [2:0]      slv_vals,
    input  logic [3*DW-1:0] slv_datas,
    input  logic [23:0]     slv_ids,
    input  logic [23:0]     slv_lens,
    input  logic            f2a_id_req,
    output logic [2:0]      a2s_acks,
    output logic            a2f_val,
    output logic [DW-1:0]   a2f_data,
    output logic [7:0]      a2f_id,
    output logic [7:0]      a2f_len,
    output logic            a2f_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      win;
    logic [1:0]      sel;
    logic [1:0]      last_winner;
    logic [1:0]      rr_start;
    logic [1:0]      min_prio;
    logic [2:0]      tie;
    logic            found;
    logic [7:0]      cnt;
    logic            win_val;
    logic [DW-1:0]   win_data;
    logic            start;
    logic            last_word;

    assign start     = f2a_id_req && (slv_reqs != 3'b000);
    assign last_word = win_val && (cnt == a2f_len);

    // Only the latched winner's valid/data are ever looked at.
    always_comb begin
        win_val  = 1'b0;
        win_data = '0;
        case (win)
            2'd0: begin
                win_val  = slv_vals[0];
                win_data = slv_datas[0 +: DW];
            end
            2'd1: begin
                win_val  = slv_vals[1];
                win_data = slv_datas[DW +: DW];
            end
            2'd2: begin
                win_val  = slv_vals[2];
                win_data = slv_datas[2*DW +: DW];
            end
            default: ;
        endcase
    end

    // Winner selection: find the best priority among requesters, then scan
    // the tied requesters starting from rr_start so the first hit wins.
    always_comb begin
        min_prio = 2'd3;
        tie      = 3'b000;
        sel      = 2'd0;
        found    = 1'b0;
`ifdef MCDF_ARB_RR_EN
        rr_start = (last_winner == 2'd2) ? 2'd0 : last_winner + 2'd1;
`else
        rr_start = 2'd0;
`endif
        for (int i = 0; i < 3; i++) begin
            if (slv_reqs[i] && (slv_prios[2*i +: 2] < min_prio)) begin
                min_prio = slv_prios[2*i +: 2];
            end
        end
        for (int i = 0; i < 3; i++) begin
            tie[i] = slv_reqs[i] && (slv_prios[2*i +: 2] == min_prio);
        end
        for (int k = 0; k < 3; k++) begin
            if (!found && tie[(int'(rr_start) + k) % 3]) begin
                sel   = 2'((int'(rr_start) + k) % 3);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = GRANT;
            GRANT:   state_nxt = XFER;
            XFER:    if (last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a2s_acks = 3'b000;
        if (state == GRANT) begin
            a2s_acks = 3'b001 << win;
        end
        a2f_busy = (state != IDLE);
    end

    // Header latch, word counter and registered data forwarding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win         <= 2'd0;
            a2f_id      <= 8'd0;
            a2f_len     <= 8'd0;
            cnt         <= 8'd0;
            last_winner <= 2'd2;
            a2f_val     <= 1'b0;
            a2f_data    <= '0;
        end else begin
            a2f_val <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        win     <= sel;
                        a2f_id  <= slv_ids[8*sel +: 8];
                        a2f_len <= slv_lens[8*sel +: 8];
                    end
                end
                GRANT: cnt <= 8'd0;
                XFER: begin
                    if (win_val) begin
                        a2f_val  <= 1'b1;
                        a2f_data <= win_data;
                        cnt      <= cnt + 8'd1;
                        if (cnt == a2f_len) begin
                            last_winner <= win;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
